// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/edge-detector block.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE,
        LOW_PEND,
        HIGH_STABLE,
        HIGH_PEND
    } db_state_t;

    // Width of the stability timer for a given required run length.
    function automatic int timer_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_edge_detector.sv
// Debounces a registered single-bit input: a new level is committed only after
// STABLE_CYCLES consecutive enabled samples, with one-cycle rise/fall pulses
// and a wrapping count of committed edges.
module debounce_edge_detector #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy
);
    import debounce_pkg::*;

    localparam int              TW         = timer_width(STABLE_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(STABLE_CYCLES - 1);

    db_state_t        r_state;
    logic [TW-1:0]    r_timer;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_edge_cnt;

    db_state_t        w_state_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_level_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_commit;

    // Next-state decode; with en low everything holds and pulses drop.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                LOW_STABLE: begin
                    if (din) begin
                        w_state_nxt = LOW_PEND;
                        w_timer_nxt = TW'(1);
                    end
                end
                LOW_PEND: begin
                    if (!din) begin
                        w_state_nxt = LOW_STABLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == TIMER_LAST) begin
                        w_state_nxt = HIGH_STABLE;
                        w_timer_nxt = '0;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                HIGH_STABLE: begin
                    if (!din) begin
                        w_state_nxt = HIGH_PEND;
                        w_timer_nxt = TW'(1);
                    end
                end
                HIGH_PEND: begin
                    if (din) begin
                        w_state_nxt = HIGH_STABLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == TIMER_LAST) begin
                        w_state_nxt = LOW_STABLE;
                        w_timer_nxt = '0;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: begin
                    w_state_nxt = LOW_STABLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    assign w_commit = w_rise_nxt | w_fall_nxt;

    // FSM, timer, level and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOW_STABLE;
            r_timer <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Committed-edge counter; a clear takes priority over a coincident commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_cnt <= '0;
        end else if (clr_cnt) begin
            r_edge_cnt <= '0;
        end else if (w_commit) begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
    end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign edge_cnt = r_edge_cnt;
    assign busy     = (r_state == LOW_PEND) || (r_state == HIGH_PEND);

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Directed self-checking bench for debounce_edge_detector (STABLE_CYCLES=4, CNT_W=8).
// Observed vector layout: {level, rise, fall, busy, edge_cnt[7:0]}.
module tb_debounce_edge_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] edge_cnt;
    logic       busy;

    logic [11:0] obs;
    int checks = 0;
    int errors = 0;

    assign obs = {level, rise, fall, busy, edge_cnt};

    always #5 clk = ~clk;

    debounce_edge_detector #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .din(din),
        .clr_cnt(clr_cnt),
        .level(level),
        .rise(rise),
        .fall(fall),
        .edge_cnt(edge_cnt),
        .busy(busy)
    );

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; din = 1'b0; clr_cnt = 1'b0;
        tick();
        din = 1'b1;
        tick();
        checks++;
        if (obs !== 12'b0000_0000_0000) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, 12'b0);
        end
        // din=1 was present on the last reset edge; release with din=0.
        reset = 1'b0; din = 1'b0;
        tick();
        checks++;
        if (obs !== 12'b0000_0000_0000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", obs, 12'b0);
        end
    endtask

    task automatic test_clean_rise();
        din = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== {4'b0001, 8'd0}) begin
                errors++;
                $display("FAIL rise_pend_edge%0d: got %b want %b", i, obs, {4'b0001, 8'd0});
            end
        end
        tick();
        checks++;
        if (obs !== {4'b1100, 8'd1}) begin
            errors++;
            $display("FAIL rise_commit: got %b want %b", obs, {4'b1100, 8'd1});
        end
        tick();
        checks++;
        if (obs !== {4'b1000, 8'd1}) begin
            errors++;
            $display("FAIL rise_pulse_end: got %b want %b", obs, {4'b1000, 8'd1});
        end
    endtask

    task automatic test_glitch();
        // High-side glitch: 3 low samples then back high.
        din = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== {4'b1001, 8'd1}) begin
                errors++;
                $display("FAIL hi_glitch_edge%0d: got %b want %b", i, obs, {4'b1001, 8'd1});
            end
        end
        din = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b1000, 8'd1}) begin
            errors++;
            $display("FAIL hi_glitch_reject: got %b want %b", obs, {4'b1000, 8'd1});
        end
        // Real fall commit.
        din = 1'b0;
        repeat (3) tick();
        tick();
        checks++;
        if (obs !== {4'b0010, 8'd2}) begin
            errors++;
            $display("FAIL fall_commit: got %b want %b", obs, {4'b0010, 8'd2});
        end
        // Low-side glitch.
        din = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (obs !== {4'b0001, 8'd2}) begin
                errors++;
                $display("FAIL lo_glitch_edge%0d: got %b want %b", i, obs, {4'b0001, 8'd2});
            end
        end
        din = 1'b0;
        tick();
        checks++;
        if (obs !== {4'b0000, 8'd2}) begin
            errors++;
            $display("FAIL lo_glitch_reject: got %b want %b", obs, {4'b0000, 8'd2});
        end
    endtask

    task automatic test_enable_freeze();
        din = 1'b1; en = 1'b1;
        repeat (2) tick();
        // Frozen with din wiggling: neither counts nor breaks the run.
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din = i[0];
            tick();
            checks++;
            if (obs !== {4'b0001, 8'd2}) begin
                errors++;
                $display("FAIL freeze_cycle%0d: got %b want %b", i, obs, {4'b0001, 8'd2});
            end
        end
        en = 1'b1; din = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b0001, 8'd2}) begin
            errors++;
            $display("FAIL freeze_resume1: got %b want %b", obs, {4'b0001, 8'd2});
        end
        tick();
        checks++;
        if (obs !== {4'b1100, 8'd3}) begin
            errors++;
            $display("FAIL freeze_resume_commit: got %b want %b", obs, {4'b1100, 8'd3});
        end
        // Dropping en right after a commit still ends the pulse.
        en = 1'b0;
        tick();
        checks++;
        if (obs !== {4'b1000, 8'd3}) begin
            errors++;
            $display("FAIL pulse_end_en_low: got %b want %b", obs, {4'b1000, 8'd3});
        end
        en = 1'b1;
    endtask

    task automatic test_wrap_clear();
        // Plain clear while idle at level 1.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (obs !== {4'b1000, 8'd0}) begin
            errors++;
            $display("FAIL clr_idle: got %b want %b", obs, {4'b1000, 8'd0});
        end
        // 256 alternating commits starting from level 1.
        for (int n = 1; n <= 256; n++) begin
            din = ~din;
            repeat (4) tick();
            if (n == 255) begin
                checks++;
                if (edge_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_pre: got %0d want %0d", edge_cnt, 255);
                end
            end
        end
        checks++;
        if (obs !== {4'b1100, 8'd0}) begin
            errors++;
            $display("FAIL wrap_zero: got %b want %b", obs, {4'b1100, 8'd0});
        end
        // One fall commit, then clear coinciding with a rise commit.
        din = 1'b0;
        repeat (4) tick();
        checks++;
        if (obs !== {4'b0010, 8'd1}) begin
            errors++;
            $display("FAIL pre_clr_commit: got %b want %b", obs, {4'b0010, 8'd1});
        end
        din = 1'b1;
        repeat (3) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (obs !== {4'b1100, 8'd0}) begin
            errors++;
            $display("FAIL clr_on_commit: got %b want %b", obs, {4'b1100, 8'd0});
        end
    endtask

    task automatic test_reset_mid();
        // Build edge_cnt=2 ending at level 1.
        din = 1'b0;
        repeat (4) tick();
        din = 1'b1;
        repeat (4) tick();
        tick();
        checks++;
        if (obs !== {4'b1000, 8'd2}) begin
            errors++;
            $display("FAIL mid_setup: got %b want %b", obs, {4'b1000, 8'd2});
        end
        // Enter HIGH_PEND with timer=2.
        din = 1'b0;
        repeat (2) tick();
        checks++;
        if (obs !== {4'b1001, 8'd2}) begin
            errors++;
            $display("FAIL mid_high_pend: got %b want %b", obs, {4'b1001, 8'd2});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b0000, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset: got %b want %b", obs, {4'b0000, 8'd0});
        end
        // Sampling restarts from LOW_STABLE after release.
        reset = 1'b0; din = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b0001, 8'd0}) begin
            errors++;
            $display("FAIL post_reset_sample: got %b want %b", obs, {4'b0001, 8'd0});
        end
        repeat (3) tick();
        checks++;
        if (obs !== {4'b1100, 8'd1}) begin
            errors++;
            $display("FAIL post_reset_commit: got %b want %b", obs, {4'b1100, 8'd1});
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_enable_freeze();
        test_wrap_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge_detector.md
Name: debounce_edge_detector

Overview:
- Downstream consumer of the single-bit enabled flip_flop stage; its din is driven by that stage's registered q output.
- Accepts a level only after it has been sampled stable for STABLE_CYCLES enabled clocks, then drives a clean debounced level.
- Emits one-cycle rise/fall pulses and keeps a running count of committed edges.
- Sits between the registered input bit and the control logic that consumes events.

Parameters:
STABLE_CYCLES, 4, consecutive enabled samples required to commit a new level; legal range >= 2
CNT_W, 8, width of edge_cnt

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
en  input  1  sample enable; when low, the debounce state freezes
din  input  1  registered input bit (flip_flop q)
clr_cnt  input  1  synchronous clear of edge_cnt
level  output  1  debounced level
rise  output  1  one-cycle pulse when a 0->1 commit occurs
fall  output  1  one-cycle pulse when a 1->0 commit occurs
edge_cnt  output  CNT_W  committed-edge counter; wraps modulo 2^CNT_W
busy  output  1  high while a candidate transition is being timed

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered or decoded from registered state only.
- Reset state: LOW_STABLE, timer=0, level=0, rise=0, fall=0, edge_cnt=0, busy=0.
- States: LOW_STABLE, LOW_PEND, HIGH_STABLE, HIGH_PEND. Timer width is $clog2(STABLE_CYCLES).
- LOW_STABLE with en=1 and din=1: go to LOW_PEND, timer<=1. With din=0: stay.
- LOW_PEND with en=1:
  - din=0: go to LOW_STABLE, timer<=0; the glitch is rejected with no pulse and no count.
  - din=1 and timer==STABLE_CYCLES-1: go to HIGH_STABLE, level<=1, rise<=1, timer<=0, edge_cnt+1.
  - din=1 otherwise: timer+1.
- HIGH_STABLE and HIGH_PEND mirror LOW_STABLE and LOW_PEND with din inverted. The commit sets level<=0 and fall<=1.
- Latency: level, rise, or fall change on the Nth consecutive enabled rising edge at which din holds the new value (N=STABLE_CYCLES).
- rise and fall: high for exactly one cycle, then forced to 0. They are never high together.
- en=0:
  - State and timer hold; rise and fall are 0 on the next cycle; level holds.
  - Cycles with en low neither count toward nor break a stability run.
- busy = (state==LOW_PEND) || (state==HIGH_PEND).
- clr_cnt: edge_cnt<=0 regardless of en. If clr_cnt coincides with a commit, the clear wins (edge_cnt=0) and the rise/fall pulse still fires.
- edge_cnt wraps: at 2^CNT_W-1, the next commit yields 0.
- Reset mid-operation, including HIGH_STABLE and either PEND state: all state returns to reset values next cycle, no fall pulse is generated, and edge_cnt returns to 0.
- A din change in the same cycle as a reset release is ignored; sampling starts on the first edge with reset=0.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] db_state_t {LOW_STABLE, LOW_PEND, HIGH_STABLE, HIGH_PEND};
  - function timer_width(int n) returning $clog2(n).
- No sub-module. The FSM, timer and counter stay in one module; the counter is too small to split.

Test Plan:
- Reset: reset=1 for 2 cycles with din toggling -> level=0, rise=0, fall=0, busy=0, edge_cnt=0.
- Clean rise (N=4, en=1): din=1 held for 4 edges -> busy=1 after edges 1-3; after edge 4: level=1, rise=1 for one cycle, edge_cnt=1, busy=0.
- Glitch reject: din=1 for 3 edges, then din=0 -> level stays 0, no rise, busy=0, edge_cnt unchanged. Repeat the same on the high side for fall.
- Enable freeze: din=1 for 2 enabled edges, en=0 for 5 cycles, then en=1 with din=1 for 2 edges -> rise after the 2nd re-enabled edge. No pulses occur while en=0.
- Counter wrap and clear (CNT_W=8):
  - 256 alternating commits -> edge_cnt=0.
  - clr_cnt=1 on a commit edge -> edge_cnt=0 and the pulse still asserted.
- Reset mid-run: level=1, state HIGH_PEND with timer=2, reset=1 for 1 cycle -> level=0, fall=0, busy=0, edge_cnt=0.
